// File: rtl/camera_link_pkg.sv
// Shared constants and types for the camera-2 UART frame link.
// Holds sync/payload sizing, sequencer states, coordinate type and checksum helper.
package camera_link_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hFF;
  localparam int         SYNC_LEN    = 3;
  localparam int         PAYLOAD_LEN = 6;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK,
    COMMIT
  } seq_state_t;

  typedef logic [11:0] coord_t;

  typedef logic [PAYLOAD_LEN-1:0][7:0] payload_t;

  function automatic logic [7:0] payload_xor(input payload_t p);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < PAYLOAD_LEN; i++) begin
      x = x ^ p[i];
    end
    return x;
  endfunction

endpackage

// File: rtl/byte_gap_timer.sv
// Loadable down-counter: reloads on clr_i or while disabled, saturates at zero.
// Ports: clk_i, rst_ni, en_i, clr_i in; expire_o is a 1-cycle strobe on reaching CYCLES.
module byte_gap_timer #(
  parameter int unsigned CYCLES = 65_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LOAD = W'(CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // A clear on the same cycle suppresses the strobe.
  assign expire_o = en_i && !clr_i && (cnt_q == W'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/camera_frame_sequencer.sv
// Turns the camera-2 UART byte stream into atomically committed hand coordinates.
// Ports: clk_65mhz, sys_rst_n, byte_valid, byte_data in; top/bot x/y, frame_valid,
// stale, frame_cnt, err_cnt out. Macro CAMERA_FRAME_CHECKSUM_EN adds the B6 XOR check.
module camera_frame_sequencer
  import camera_link_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65_000,
  parameter int unsigned STALE_CYCLES   = 6_500_000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk_65mhz,
  input  logic             sys_rst_n,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output coord_t           top_x,
  output coord_t           top_y,
  output coord_t           bot_x,
  output coord_t           bot_y,
  output logic             frame_valid,
  output logic             stale,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] SYNC_LAST = 2'(SYNC_LEN - 1);
  localparam logic [2:0] IDX_LAST  = 3'(PAYLOAD_LEN - 1);

  seq_state_t       state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [2:0]       idx_q, idx_d;
  payload_t         pay_q, pay_d;
  coord_t           top_x_q, top_x_d;
  coord_t           top_y_q, top_y_d;
  coord_t           bot_x_q, bot_x_d;
  coord_t           bot_y_q, bot_y_d;
  logic             fv_q, fv_d;
  logic             stale_q, stale_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic             abort;
  logic             gap_en, gap_exp;
  logic             commit, stale_exp;

  assign gap_en = (state_q == PAYLOAD) || (state_q == CHECK);
  assign commit = (state_q == COMMIT);

  byte_gap_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_gap (
    .clk_i   (clk_65mhz),
    .rst_ni  (sys_rst_n),
    .en_i    (gap_en),
    .clr_i   (byte_valid),
    .expire_o(gap_exp)
  );

  byte_gap_timer #(
    .CYCLES(STALE_CYCLES)
  ) u_stale (
    .clk_i   (clk_65mhz),
    .rst_ni  (sys_rst_n),
    .en_i    (1'b1),
    .clr_i   (commit),
    .expire_o(stale_exp)
  );

  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    idx_d   = idx_q;
    pay_d   = pay_q;
    top_x_d = top_x_q;
    top_y_d = top_y_q;
    bot_x_d = bot_x_q;
    bot_y_d = bot_y_q;
    fv_d    = 1'b0;
    stale_d = stale_q;
    fcnt_d  = fcnt_q;
    ecnt_d  = ecnt_q;
    abort   = 1'b0;

    if (stale_exp) stale_d = 1'b1;

    unique case (state_q)
      // COMMIT also runs the hunt logic so a byte
      // arriving in that cycle is not lost.
      HUNT, COMMIT: begin
        if (commit) begin
          top_x_d = {pay_q[0], pay_q[1][7:4]};
          top_y_d = {pay_q[1][3:0], pay_q[2]};
          bot_x_d = {pay_q[3], pay_q[4][7:4]};
          bot_y_d = {pay_q[4][3:0], pay_q[5]};
          fv_d    = 1'b1;
          stale_d = 1'b0;
          state_d = HUNT;
          if (~&fcnt_q) fcnt_d = fcnt_q + CNT_W'(1);
        end
        if (byte_valid) begin
          if (byte_data == SYNC_BYTE) begin
            if (sync_q == SYNC_LAST) begin
              state_d = PAYLOAD;
              sync_d  = '0;
              idx_d   = '0;
            end else begin
              sync_d = sync_q + 2'd1;
            end
          end else begin
            sync_d = '0;
          end
        end
      end
      PAYLOAD: begin
        if (byte_valid) begin
          pay_d[idx_q] = byte_data;
          idx_d = idx_q + 3'd1;
          if (idx_q == IDX_LAST) begin
`ifdef CAMERA_FRAME_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = COMMIT;
`endif
          end
        end else if (gap_exp) begin
          abort = 1'b1;
        end
      end
      CHECK: begin
`ifdef CAMERA_FRAME_CHECKSUM_EN
        if (byte_valid) begin
          if (byte_data == payload_xor(pay_q)) begin
            state_d = COMMIT;
          end else begin
            abort = 1'b1;
          end
        end else if (gap_exp) begin
          abort = 1'b1;
        end
`else
        state_d = HUNT;
`endif
      end
      default: state_d = HUNT;
    endcase

    if (abort) begin
      state_d = HUNT;
      sync_d  = '0;
      if (~&ecnt_q) ecnt_d = ecnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_65mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= HUNT;
      sync_q  <= '0;
      idx_q   <= '0;
      pay_q   <= '0;
      top_x_q <= '0;
      top_y_q <= '0;
      bot_x_q <= '0;
      bot_y_q <= '0;
      fv_q    <= 1'b0;
      stale_q <= 1'b1;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      idx_q   <= idx_d;
      pay_q   <= pay_d;
      top_x_q <= top_x_d;
      top_y_q <= top_y_d;
      bot_x_q <= bot_x_d;
      bot_y_q <= bot_y_d;
      fv_q    <= fv_d;
      stale_q <= stale_d;
      fcnt_q  <= fcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign top_x       = top_x_q;
  assign top_y       = top_y_q;
  assign bot_x       = bot_x_q;
  assign bot_y       = bot_y_q;
  assign frame_valid = fv_q;
  assign stale       = stale_q;
  assign frame_cnt   = fcnt_q;
  assign err_cnt     = ecnt_q;

endmodule

// File: tb/tb_camera_frame_sequencer.sv
// Self-checking bench for camera_frame_sequencer with shortened timers.
// Build with +define+CAMERA_FRAME_CHECKSUM_EN to exercise the B6 check.
module tb_camera_frame_sequencer;

  localparam int TO = 20;
  localparam int ST = 300;
  localparam int CW = 3;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bv;
  logic [7:0]    bd;
  logic [11:0]   tx, ty, bx, by;
  logic          fv, stale;
  logic [CW-1:0] fcnt, ecnt;

  logic [47:0] exp_q[$];
  logic [47:0] obs_q[$];
  logic [47:0] last_exp;
  int compared = 0;
  int mismatched = 0;
  int fv_seen = 0;
  logic [CW-1:0] exp_frames;
  logic [CW-1:0] exp_err;

  camera_frame_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .STALE_CYCLES  (ST),
    .CNT_W         (CW)
  ) dut (
    .clk_65mhz  (clk),
    .sys_rst_n  (rst_n),
    .byte_valid (bv),
    .byte_data  (bd),
    .top_x      (tx),
    .top_y      (ty),
    .bot_x      (bx),
    .bot_y      (by),
    .frame_valid(fv),
    .stale      (stale),
    .frame_cnt  (fcnt),
    .err_cnt    (ecnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fv) begin
      obs_q.push_back({tx, ty, bx, by});
      fv_seen++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bv = 1'b1;
    bd = b;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bv = 1'b0;
    bd = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_obs(input int n);
    for (int i = 0; i < 30 && obs_q.size() < n; i++) @(negedge clk);
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  task automatic push_exp(input logic [47:0] f);
    exp_q.push_back(f);
    last_exp = f;
    exp_frames = sat(exp_frames);
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4, b5);
    repeat (3) send_byte(8'hFF);
    send_byte(b0); send_byte(b1); send_byte(b2);
    send_byte(b3); send_byte(b4); send_byte(b5);
`ifdef CAMERA_FRAME_CHECKSUM_EN
    send_byte(b0 ^ b1 ^ b2 ^ b3 ^ b4 ^ b5);
`endif
    push_exp({b0, b1, b2, b3, b4, b5});
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bv = 1'b0; bd = 8'h00;
    exp_frames = '0; exp_err = '0; last_exp = '0;
    repeat (3) @(negedge clk);
    compared++;
    if ({tx, ty, bx, by} !== 48'd0) begin
      mismatched++;
      $display("FAIL reset_coords: got %h want 0", {tx, ty, bx, by});
    end
    compared++;
    if (fv !== 1'b0 || stale !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_flags: fv=%b stale=%b want fv=0 stale=1", fv, stale);
    end
    compared++;
    if (fcnt !== '0 || ecnt !== '0) begin
      mismatched++;
      $display("FAIL reset_cnt: frame_cnt=%0d err_cnt=%0d want 0/0", fcnt, ecnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean_frame;
    int f0;
    logic [47:0] o, e;
    f0 = fv_seen;
    send_frame(8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34, 8'h56);
    idle(1);
    wait_obs(1);
    while (exp_q.size() > 0) begin
      compared++;
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        mismatched++;
        $display("FAIL clean_frame: no frame_valid, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("FAIL clean_frame: coords %h want %h", o, e);
        end
      end
    end
    idle(2);
    compared++;
    if ({tx, ty, bx, by} !== {12'hABC, 12'hDEF, 12'h123, 12'h456}) begin
      mismatched++;
      $display("FAIL clean_coords: got %h want abcdef123456", {tx, ty, bx, by});
    end
    compared++;
    if (fcnt !== 3'd1 || fv_seen - f0 != 1) begin
      mismatched++;
      $display("FAIL clean_count: frame_cnt=%0d pulses=%0d want 1/1", fcnt, fv_seen - f0);
    end
    compared++;
    if (stale !== 1'b0) begin
      mismatched++;
      $display("FAIL clean_stale: stale=%b want 0", stale);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [47:0] o, e;
    repeat (3) send_byte(8'hFF);
    send_byte(8'h77); send_byte(8'h88); send_byte(8'h99);
    @(negedge clk);
    bv = 1'b0;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({tx, ty, bx, by} !== 48'd0 || fv !== 1'b0 || stale !== 1'b1) begin
      mismatched++;
      $display("FAIL midreset_out: coords=%h fv=%b stale=%b want 0/0/1", {tx, ty, bx, by}, fv, stale);
    end
    compared++;
    if (fcnt !== '0 || ecnt !== '0) begin
      mismatched++;
      $display("FAIL midreset_cnt: frame_cnt=%0d err_cnt=%0d want 0/0", fcnt, ecnt);
    end
    exp_frames = '0; exp_err = '0; last_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    idle(1);
    wait_obs(1);
    while (exp_q.size() > 0) begin
      compared++;
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        mismatched++;
        $display("FAIL midreset_frame: no frame_valid, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("FAIL midreset_frame: coords %h want %h", o, e);
        end
      end
    end
    idle(2);
    compared++;
    if (fcnt !== exp_frames) begin
      mismatched++;
      $display("FAIL midreset_fcnt: frame_cnt=%0d want %0d", fcnt, exp_frames);
    end
  endtask

  task automatic test_false_sync;
    int f0;
    logic [47:0] o, e;
    f0 = fv_seen;
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00);
    repeat (3) send_byte(8'hFF);
    repeat (6) send_byte(8'h00);
`ifdef CAMERA_FRAME_CHECKSUM_EN
    send_byte(8'h00);
`endif
    push_exp(48'd0);
    idle(1);
    wait_obs(1);
    while (exp_q.size() > 0) begin
      compared++;
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        mismatched++;
        $display("FAIL false_sync: no frame_valid, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("FAIL false_sync: coords %h want %h", o, e);
        end
      end
    end
    idle(2);
    compared++;
    if (fv_seen - f0 != 1 || fcnt !== exp_frames) begin
      mismatched++;
      $display("FAIL false_sync_cnt: pulses=%0d frame_cnt=%0d want 1/%0d", fv_seen - f0, fcnt, exp_frames);
    end
  endtask

  // The second frame's first sync byte lands in the COMMIT
  // cycle of the all-0xFF frame.
  task automatic test_back_to_back;
    int f0;
    logic [47:0] o, e;
    f0 = fv_seen;
    repeat (9) send_byte(8'hFF);
`ifdef CAMERA_FRAME_CHECKSUM_EN
    send_byte(8'h00);
`endif
    push_exp({4{12'hFFF}});
    send_frame(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC);
    idle(1);
    wait_obs(2);
    while (exp_q.size() > 0) begin
      compared++;
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        mismatched++;
        $display("FAIL back_to_back: no frame_valid, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("FAIL back_to_back: coords %h want %h", o, e);
        end
      end
    end
    idle(2);
    compared++;
    if (fv_seen - f0 != 2 || fcnt !== exp_frames) begin
      mismatched++;
      $display("FAIL back_to_back_cnt: pulses=%0d frame_cnt=%0d want 2/%0d", fv_seen - f0, fcnt, exp_frames);
    end
  endtask

  task automatic test_gap_refresh;
    logic [47:0] o, e;
    logic [7:0] b [6];
    logic [7:0] x;
    b = '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h69, 8'h96};
    x = 8'h00;
    repeat (3) send_byte(8'hFF);
    for (int i = 0; i < 6; i++) begin
      idle(TO - 4);
      send_byte(b[i]);
      x = x ^ b[i];
    end
`ifdef CAMERA_FRAME_CHECKSUM_EN
    idle(TO - 4);
    send_byte(x);
`endif
    push_exp({b[0], b[1], b[2], b[3], b[4], b[5]});
    idle(1);
    wait_obs(1);
    while (exp_q.size() > 0) begin
      compared++;
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        mismatched++;
        $display("FAIL gap_refresh: no frame_valid, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("FAIL gap_refresh: coords %h want %h", o, e);
        end
      end
    end
    compared++;
    if (ecnt !== exp_err) begin
      mismatched++;
      $display("FAIL gap_refresh_err: err_cnt=%0d want %0d", ecnt, exp_err);
    end
  endtask

  task automatic test_timeout;
    int f0;
    logic [47:0] o, e;
    f0 = fv_seen;
    repeat (3) send_byte(8'hFF);
    send_byte(8'h10); send_byte(8'h20);
    send_byte(8'h30); send_byte(8'h40);
    idle(TO - 2);
    compared++;
    if (ecnt !== exp_err) begin
      mismatched++;
      $display("FAIL timeout_early: err_cnt=%0d want %0d", ecnt, exp_err);
    end
    idle(5);
    exp_err = sat(exp_err);
    compared++;
    if (ecnt !== exp_err) begin
      mismatched++;
      $display("FAIL timeout_err: err_cnt=%0d want %0d", ecnt, exp_err);
    end
    compared++;
    if ({tx, ty, bx, by} !== last_exp || fv_seen != f0) begin
      mismatched++;
      $display("FAIL timeout_hold: coords=%h pulses=%0d want %h/0", {tx, ty, bx, by}, fv_seen - f0, last_exp);
    end
    compared++;
    if (stale !== 1'b0) begin
      mismatched++;
      $display("FAIL stale_early: stale=%b want 0", stale);
    end
    idle(ST + 10);
    compared++;
    if (stale !== 1'b1) begin
      mismatched++;
      $display("FAIL stale_set: stale=%b want 1", stale);
    end
    send_frame(8'hC0, 8'hFF, 8'hEE, 8'h0D, 8'h15, 8'h70);
    idle(1);
    wait_obs(1);
    while (exp_q.size() > 0) begin
      compared++;
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        mismatched++;
        $display("FAIL timeout_recover: no frame_valid, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("FAIL timeout_recover: coords %h want %h", o, e);
        end
      end
    end
    idle(2);
    compared++;
    if (stale !== 1'b0) begin
      mismatched++;
      $display("FAIL stale_clear: stale=%b want 0", stale);
    end
  endtask

`ifdef CAMERA_FRAME_CHECKSUM_EN
  task automatic test_checksum;
    int f0;
    logic [47:0] o, e;
    f0 = fv_seen;
    repeat (3) send_byte(8'hFF);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    send_byte(8'h08);
    idle(4);
    exp_err = sat(exp_err);
    compared++;
    if (ecnt !== exp_err || fv_seen != f0) begin
      mismatched++;
      $display("FAIL csum_bad: err_cnt=%0d pulses=%0d want %0d/0", ecnt, fv_seen - f0, exp_err);
    end
    compared++;
    if ({tx, ty, bx, by} !== last_exp) begin
      mismatched++;
      $display("FAIL csum_hold: coords=%h want %h", {tx, ty, bx, by}, last_exp);
    end
    repeat (3) send_byte(8'hFF);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    send_byte(8'h07);
    push_exp({12'h010, 12'h203, 12'h040, 12'h506});
    idle(1);
    wait_obs(1);
    while (exp_q.size() > 0) begin
      compared++;
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        mismatched++;
        $display("FAIL csum_good: no frame_valid, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("FAIL csum_good: coords %h want %h", o, e);
        end
      end
    end
  endtask
`endif

  task automatic test_saturation;
    logic [47:0] o, e;
    for (int k = 0; k < 4; k++) begin
      send_frame(8'(k * 16 + 1), 8'h5E, 8'h7C, 8'h9B, 8'hAD, 8'(k));
      idle(2);
    end
    wait_obs(4);
    while (exp_q.size() > 0) begin
      compared++;
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        mismatched++;
        $display("FAIL saturation: no frame_valid, want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("FAIL saturation: coords %h want %h", o, e);
        end
      end
    end
    idle(2);
    compared++;
    if (fcnt !== exp_frames || fcnt !== CMAX) begin
      mismatched++;
      $display("FAIL frame_cnt_sat: frame_cnt=%0d want %0d", fcnt, exp_frames);
    end
  endtask

  initial begin
    test_reset;
    test_clean_frame;
    test_reset_mid_frame;
    test_false_sync;
    test_back_to_back;
    test_gap_refresh;
    test_timeout;
`ifdef CAMERA_FRAME_CHECKSUM_EN
    test_checksum;
`endif
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
